// File: rtl/mem_sram_responder.sv
// mem_sram_responder: peripheral-side responder for the req/gnt/recv/ack
// memory interface. It performs single-cycle accesses to a synchronous SRAM
// macro and returns in-order responses. Responses are buffered in a 2-entry
// FIFO so each one is held until it is acked.
// Optional build macro: MEM_RSP_WAIT_EN adds a post-grant wait counter that
// throttles grants to one every WAIT_CYCLES+1 cycles.
module mem_sram_responder #(
  parameter int unsigned ADDR_W      = 14,
  parameter logic [31:0] BASE        = 32'h2000_0000,
  parameter bit          READ_ONLY   = 1'b0,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              mem_req,
  input  logic              mem_wen,
  input  logic [3:0]        mem_strb,
  input  logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_addr,
  output logic              mem_gnt,
  output logic              mem_recv,
  input  logic              mem_ack,
  output logic              mem_error,
  output logic [31:0]       mem_rdata,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [3:0]        sram_strb,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  // The window limit is computed on 33 bits so that a window ending exactly
  // at 4 GiB does not wrap around to zero.
  localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'd4 << ADDR_W);

  logic        err;
  logic        grant;
  logic        wait_busy;

  logic        s1_valid;
  logic        s1_err;
  logic        s1_wen;
  logic [31:0] s1_rdata;

  logic        fifo_err   [2];
  logic [31:0] fifo_rdata [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  occ;
  logic        push;
  logic        pop;

  // Address window and write-permission decode.
  assign err = (mem_addr < BASE) || ({1'b0, mem_addr} >= LIMIT) ||
               (READ_ONLY && mem_wen);

  // Accept only when a buffer slot is guaranteed for the response. This uses
  // registered state only, so there is no combinational path from mem_ack.
  assign mem_gnt = g_resetn && !wait_busy &&
                   (({1'b0, occ} + {2'b00, s1_valid}) < 3'd2);
  assign grant   = mem_req && mem_gnt;

  // Errored requests never reach the macro.
  assign sram_cen   = grant && !err;
  assign sram_wen   = mem_wen;
  assign sram_strb  = mem_strb;
  assign sram_addr  = mem_addr[ADDR_W+1:2];
  assign sram_wdata = mem_wdata;

  // Writes and errors return zero data.
  assign s1_rdata = (s1_err || s1_wen) ? 32'h0 : sram_rdata;

  // The FIFO head takes priority over stage 1, which preserves request order.
  assign mem_recv  = (occ != 2'd0) || s1_valid;
  assign mem_error = (occ != 2'd0) ? fifo_err[rd_ptr]   : (s1_valid && s1_err);
  assign mem_rdata = (occ != 2'd0) ? fifo_rdata[rd_ptr] : (s1_valid ? s1_rdata : 32'h0);

  // A stage-1 response that is acked while the FIFO is empty bypasses the FIFO.
  assign pop  = (occ != 2'd0) && mem_ack;
  assign push = s1_valid && !((occ == 2'd0) && mem_ack);

`ifdef MEM_RSP_WAIT_EN
  logic [7:0] wait_cnt;

  // Post-grant wait counter: load on grant, count down to zero.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wait_cnt <= 8'd0;
    end else if (grant) begin
      wait_cnt <= 8'(WAIT_CYCLES);
    end else if (wait_cnt != 8'd0) begin
      wait_cnt <= wait_cnt - 8'd1;
    end
  end

  assign wait_busy = (wait_cnt != 8'd0);
`else
  assign wait_busy = 1'b0;
`endif

  // Stage-1 tracking, FIFO pointers and occupancy.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_wen   <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      occ      <= 2'd0;
    end else begin
      s1_valid <= grant;
      if (grant) begin
        s1_err <= err;
        s1_wen <= mem_wen;
      end
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push) wr_ptr <= ~wr_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // FIFO storage. Validity is tracked by occ, so the data needs no reset.
  always_ff @(posedge g_clk) begin
    if (push) begin
      fifo_err[wr_ptr]   <= s1_err;
      fifo_rdata[wr_ptr] <= s1_rdata;
    end
  end

endmodule

// File: tb/tb_mem_sram_responder.sv
// Directed testbench for mem_sram_responder: a RAM instance and a READ_ONLY
// instance, each with a behavioural synchronous SRAM.
module tb_mem_sram_responder;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        req, wen, ack;
  logic [3:0]  strb;
  logic [31:0] wdata, addr;
  logic        gnt, recv, error;
  logic [31:0] rdata;
  logic        sram_cen, sram_wen;
  logic [3:0]  sram_strb;
  logic [13:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = 32'h0;

  logic        rom_req, rom_wen, rom_ack;
  logic [31:0] rom_addr;
  logic        rom_gnt, rom_recv, rom_error;
  logic [31:0] rom_rdata;
  logic        rom_cen, rom_swen;
  logic [3:0]  rom_sstrb;
  logic [13:0] rom_saddr;
  logic [31:0] rom_swdata;
  logic [31:0] rom_srdata = 32'h0;

  logic [31:0] sram [0:16383];

  int ntests = 0;
  int nfail  = 0;

  always #5 g_clk = ~g_clk;

  mem_sram_responder #(.ADDR_W(14), .BASE(BASE), .READ_ONLY(1'b0), .WAIT_CYCLES(2)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .mem_req(req), .mem_wen(wen), .mem_strb(strb), .mem_wdata(wdata), .mem_addr(addr),
    .mem_gnt(gnt), .mem_recv(recv), .mem_ack(ack), .mem_error(error), .mem_rdata(rdata),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_strb(sram_strb), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  mem_sram_responder #(.ADDR_W(14), .BASE(BASE), .READ_ONLY(1'b1), .WAIT_CYCLES(2)) rom (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .mem_req(rom_req), .mem_wen(rom_wen), .mem_strb(4'hF), .mem_wdata(32'h0), .mem_addr(rom_addr),
    .mem_gnt(rom_gnt), .mem_recv(rom_recv), .mem_ack(rom_ack), .mem_error(rom_error),
    .mem_rdata(rom_rdata), .sram_cen(rom_cen), .sram_wen(rom_swen), .sram_strb(rom_sstrb),
    .sram_addr(rom_saddr), .sram_wdata(rom_swdata), .sram_rdata(rom_srdata)
  );

  // RAM model: byte-strobed writes, one-cycle read latency, known words loaded in reset.
  always @(posedge g_clk) begin
    if (!g_resetn) begin
      sram[2] <= 32'h0000_0000;
      sram[4] <= 32'hDEAD_BEEF;
      sram[5] <= 32'hCAFE_F00D;
    end else if (sram_cen) begin
      if (sram_wen) begin
        for (int b = 0; b < 4; b++)
          if (sram_strb[b]) sram[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram[sram_addr];
      end
    end
  end

  // ROM model: each word reads back as its own word address.
  always @(posedge g_clk) begin
    if (rom_cen) rom_srdata <= {18'h0, rom_saddr};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge g_clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] a, input logic k);
    req = r; wen = w; strb = s; wdata = d; addr = a; ack = k;
    #1;
  endtask

  initial begin
    g_resetn = 1'b0;
    req = 0; wen = 0; strb = 4'h0; wdata = 0; addr = 0; ack = 0;
    rom_req = 0; rom_wen = 0; rom_addr = 0; rom_ack = 1;

    // Reset state
    cyc(); #1;
    chk("rst_gnt", {31'h0, gnt}, 32'd0);
    chk("rst_recv", {31'h0, recv}, 32'd0);
    chk("rst_error", {31'h0, error}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_cen", {31'h0, sram_cen}, 32'd0);
    g_resetn = 1'b1;
    #1;
    chk("rst_rel_gnt", {31'h0, gnt}, 32'd1);
    cyc();

    // 1: read word 4, latency 1
    drive(1, 0, 4'h0, 0, BASE + 32'h10, 1);
    chk("t1_gnt", {31'h0, gnt}, 32'd1);
    chk("t1_cen", {31'h0, sram_cen}, 32'd1);
    chk("t1_saddr", {18'h0, sram_addr}, 32'd4);
    cyc();
    drive(0, 0, 4'h0, 0, 0, 1);
    chk("t1_recv", {31'h0, recv}, 32'd1);
    chk("t1_rdata", rdata, 32'hDEAD_BEEF);
    chk("t1_err", {31'h0, error}, 32'd0);
    cyc();
    chk("t1_idle", {31'h0, recv}, 32'd0);

    // 2: partial write then read back
    drive(1, 1, 4'b0011, 32'h1122_3344, BASE + 32'h8, 1);
    chk("t2_cen", {31'h0, sram_cen}, 32'd1);
    chk("t2_swen", {31'h0, sram_wen}, 32'd1);
    cyc();
    drive(1, 0, 4'h0, 0, BASE + 32'h8, 1);
    chk("t2_wr_recv", {31'h0, recv}, 32'd1);
    chk("t2_wr_rdata", rdata, 32'h0);
    cyc();
    drive(0, 0, 4'h0, 0, 0, 1);
    chk("t2_rd_rdata", rdata, 32'h0000_3344);
    cyc();

    // 3: back-pressure with ack low
    drive(1, 0, 4'h0, 0, BASE + 32'h10, 0);
    chk("t3_gnt_a", {31'h0, gnt}, 32'd1);
    cyc();
    drive(1, 0, 4'h0, 0, BASE + 32'h8, 0);
    chk("t3_gnt_b", {31'h0, gnt}, 32'd1);
    chk("t3_rdata_b", rdata, 32'hDEAD_BEEF);
    cyc();
    drive(1, 0, 4'h0, 0, BASE + 32'h14, 0);
    chk("t3_gnt_c", {31'h0, gnt}, 32'd0);
    chk("t3_recv_c", {31'h0, recv}, 32'd1);
    chk("t3_rdata_c", rdata, 32'hDEAD_BEEF);
    cyc();
    drive(1, 0, 4'h0, 0, BASE + 32'h14, 1);
    chk("t3_gnt_full", {31'h0, gnt}, 32'd0);
    chk("t3_rdata_d", rdata, 32'hDEAD_BEEF);
    cyc();
    drive(1, 0, 4'h0, 0, BASE + 32'h14, 0);
    chk("t3_gnt_reassert", {31'h0, gnt}, 32'd1);
    chk("t3_rdata_e", rdata, 32'h0000_3344);
    cyc();
    drive(0, 0, 4'h0, 0, 0, 1);
    chk("t3_rdata_f", rdata, 32'h0000_3344);
    cyc();
    drive(0, 0, 4'h0, 0, 0, 1);
    chk("t3_rdata_g", rdata, 32'hCAFE_F00D);
    cyc();
    chk("t3_drained", {31'h0, recv}, 32'd0);

    // 4: out-of-window addresses
    drive(1, 0, 4'h0, 0, 32'h1FFF_FFFC, 1);
    chk("t4_lo_cen", {31'h0, sram_cen}, 32'd0);
    chk("t4_lo_gnt", {31'h0, gnt}, 32'd1);
    cyc();
    drive(1, 0, 4'h0, 0, BASE + 32'h1_0000, 1);
    chk("t4_lo_err", {31'h0, error}, 32'd1);
    chk("t4_lo_rdata", rdata, 32'h0);
    chk("t4_hi_cen", {31'h0, sram_cen}, 32'd0);
    cyc();
    drive(0, 0, 4'h0, 0, 0, 1);
    chk("t4_hi_err", {31'h0, error}, 32'd1);
    chk("t4_hi_rdata", rdata, 32'h0);
    cyc();

    // 6: throughput with req and ack held high
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 4'h0, 0, BASE + 32'h10, 1);
`ifdef MEM_RSP_WAIT_EN
      chk($sformatf("t6_gnt_%0d", i), {31'h0, gnt}, (i % 3 == 0) ? 32'd1 : 32'd0);
`else
      chk($sformatf("t6_gnt_%0d", i), {31'h0, gnt}, 32'd1);
      if (i > 0) chk($sformatf("t6_rdata_%0d", i), rdata, 32'hDEAD_BEEF);
`endif
      cyc();
    end
    drive(0, 0, 4'h0, 0, 0, 1);
    cyc(); cyc(); cyc();

    // 5a: read-only instance rejects writes
    rom_req = 1; rom_wen = 1; rom_addr = BASE; #1;
    chk("t5_rom_gnt", {31'h0, rom_gnt}, 32'd1);
    chk("t5_rom_cen_w", {31'h0, rom_cen}, 32'd0);
    cyc();
    rom_wen = 0; rom_addr = BASE + 32'h10; #1;
    chk("t5_rom_err", {31'h0, rom_error}, 32'd1);
    chk("t5_rom_wr_rdata", rom_rdata, 32'h0);
    chk("t5_rom_cen_r", {31'h0, rom_cen}, 32'd1);
    cyc();
    rom_req = 0; #1;
    chk("t5_rom_rd_err", {31'h0, rom_error}, 32'd0);
    chk("t5_rom_rd_rdata", rom_rdata, 32'd4);
    cyc();

    // 5b: reset with two responses buffered
    drive(1, 0, 4'h0, 0, BASE + 32'h10, 0);
    cyc();
    drive(1, 0, 4'h0, 0, BASE + 32'h14, 0);
    cyc();
    drive(0, 0, 4'h0, 0, 0, 0);
    chk("t5_full_gnt", {31'h0, gnt}, 32'd0);
    chk("t5_full_recv", {31'h0, recv}, 32'd1);
    g_resetn = 1'b0;
    cyc();
    chk("t5_rst_recv", {31'h0, recv}, 32'd0);
    chk("t5_rst_gnt", {31'h0, gnt}, 32'd0);
    g_resetn = 1'b1;
    #1;
    chk("t5_rel_gnt", {31'h0, gnt}, 32'd1);
    chk("t5_rel_recv", {31'h0, recv}, 32'd0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
